// File: rtl/complex_acc_pkg.sv
// Shared state encoding and default widths for the complex accumulator slice.
package complex_acc_pkg;

  localparam int unsigned DEF_IN_WIDTH  = 18;
  localparam int unsigned DEF_ACC_WIDTH = 24;
  localparam int unsigned DEF_LEN_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/complex_sat_add.sv
// One component of the accumulator: sign-extended add with clamp to ACC_WIDTH.
module complex_sat_add #(
  parameter int unsigned IN_WIDTH  = 18,
  parameter int unsigned ACC_WIDTH = 24
) (
  input  logic [ACC_WIDTH-1:0] i_acc,
  input  logic [IN_WIDTH-1:0]  i_add,
  input  logic                 i_load,
  output logic [ACC_WIDTH-1:0] o_sum,
  output logic                 o_sat
);

  localparam int unsigned EXT = ACC_WIDTH + 1 - IN_WIDTH;

  logic [ACC_WIDTH:0] w_add_ext;
  logic [ACC_WIDTH:0] w_acc_ext;
  logic [ACC_WIDTH:0] w_sum;

  assign w_add_ext = {{EXT{i_add[IN_WIDTH-1]}}, i_add};
  assign w_acc_ext = {i_acc[ACC_WIDTH-1], i_acc};
  assign w_sum     = w_acc_ext + w_add_ext;

  always_comb begin
    o_sum = w_sum[ACC_WIDTH-1:0];
    o_sat = 1'b0;
    if (i_load) begin
      o_sum = w_add_ext[ACC_WIDTH-1:0];
    end else if (w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1]) begin
      // top two bits disagree: clamp towards the sign of the true result
      o_sat = 1'b1;
      o_sum = {w_sum[ACC_WIDTH], {(ACC_WIDTH-1){~w_sum[ACC_WIDTH]}}};
    end
  end

endmodule

// File: rtl/complex_acc.sv
// Accumulates a programmable number of complex products and presents the
// saturated sum on a valid/ready output.
module complex_acc
  import complex_acc_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = DEF_IN_WIDTH,
  parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int unsigned LEN_WIDTH = DEF_LEN_WIDTH
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   sw_rst,
  input  logic                   in_val,
  output logic                   in_ready,
  input  logic [2*IN_WIDTH-1:0]  in_data,
  input  logic [LEN_WIDTH-1:0]   len,
  output logic                   out_val,
  input  logic                   out_ready,
  output logic [2*ACC_WIDTH-1:0] out_data,
  output logic                   out_ovf
);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [LEN_WIDTH-1:0]   r_len;
  logic [LEN_WIDTH-1:0]   r_cnt;
  logic [LEN_WIDTH-1:0]   w_len_eff;
  logic [LEN_WIDTH-1:0]   w_cnt_inc;
  logic [ACC_WIDTH-1:0]   r_acc_re;
  logic [ACC_WIDTH-1:0]   r_acc_im;
  logic [ACC_WIDTH-1:0]   w_sum_re;
  logic [ACC_WIDTH-1:0]   w_sum_im;
  logic                   r_ovf;
  logic                   w_sat_re;
  logic                   w_sat_im;
  logic                   w_in_beat;
  logic                   w_load;

  assign w_in_beat = in_val & in_ready;
  assign w_load    = (r_state == ST_IDLE);
  assign w_len_eff = (len == '0) ? LEN_WIDTH'(1) : len;
  assign w_cnt_inc = r_cnt + LEN_WIDTH'(1);

  complex_sat_add #(.IN_WIDTH(IN_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_sat_re (
    .i_acc  (r_acc_re),
    .i_add  (in_data[2*IN_WIDTH-1 -: IN_WIDTH]),
    .i_load (w_load),
    .o_sum  (w_sum_re),
    .o_sat  (w_sat_re)
  );

  complex_sat_add #(.IN_WIDTH(IN_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_sat_im (
    .i_acc  (r_acc_im),
    .i_add  (in_data[IN_WIDTH-1:0]),
    .i_load (w_load),
    .o_sum  (w_sum_im),
    .o_sat  (w_sat_im)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b1;
    out_val     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_val) w_state_nxt = (w_len_eff == LEN_WIDTH'(1)) ? ST_OUT : ST_ACC;
      end
      ST_ACC: begin
        if (in_val && (w_cnt_inc == r_len)) w_state_nxt = ST_OUT;
      end
      ST_OUT: begin
        in_ready = 1'b0;
        out_val  = 1'b1;
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (sw_rst) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_len    <= '0;
      r_cnt    <= '0;
      r_acc_re <= '0;
      r_acc_im <= '0;
      r_ovf    <= 1'b0;
    end else if (sw_rst) begin
      r_len    <= '0;
      r_cnt    <= '0;
      r_acc_re <= '0;
      r_acc_im <= '0;
      r_ovf    <= 1'b0;
    end else if (w_in_beat) begin
      r_acc_re <= w_sum_re;
      r_acc_im <= w_sum_im;
      if (w_load) begin
        r_len <= w_len_eff;
        r_cnt <= LEN_WIDTH'(1);
        r_ovf <= 1'b0;
      end else begin
        r_cnt <= w_cnt_inc;
        r_ovf <= r_ovf | w_sat_re | w_sat_im;
      end
    end
  end

  assign out_data = {r_acc_re, r_acc_im};
  assign out_ovf  = r_ovf;

endmodule

// File: tb/tb_complex_acc.sv
// Scoreboard bench: default-width and 18-bit-accumulator instances share stimulus.
module tb_complex_acc;

  localparam int IW  = 18;
  localparam int AW  = 24;
  localparam int AWS = 18;
  localparam int LW  = 8;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            sw_rst = 1'b0;
  logic            in_val = 1'b0;
  logic            out_ready = 1'b1;
  logic [2*IW-1:0] in_data = '0;
  logic [LW-1:0]   len = '0;

  logic             in_ready, out_val, out_ovf;
  logic [2*AW-1:0]  out_data;
  logic             in_ready_s, out_val_s, out_ovf_s;
  logic [2*AWS-1:0] out_data_s;

  always #5 clk = ~clk;

  complex_acc u_dut (
    .clk(clk), .rstn(rstn), .sw_rst(sw_rst), .in_val(in_val), .in_ready(in_ready),
    .in_data(in_data), .len(len), .out_val(out_val), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf)
  );

  complex_acc #(.IN_WIDTH(IW), .ACC_WIDTH(AWS), .LEN_WIDTH(LW)) u_dut_s (
    .clk(clk), .rstn(rstn), .sw_rst(sw_rst), .in_val(in_val), .in_ready(in_ready_s),
    .in_data(in_data), .len(len), .out_val(out_val_s), .out_ready(out_ready),
    .out_data(out_data_s), .out_ovf(out_ovf_s)
  );

  typedef struct {
    longint re_w, im_w, re_s, im_s;
    bit     ovf_w, ovf_s;
  } exp_t;

  exp_t   sb[$];
  int     n_vec = 0;
  int     n_err = 0;
  int     m_cnt = 0;
  int     m_len = 0;
  longint a_re_w, a_im_w, a_re_s, a_im_s;
  bit     o_w, o_s;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v, input int w, inout bit f);
    longint mx = (longint'(1) << (w - 1)) - 1;
    if (v > mx) begin f = 1'b1; return mx; end
    if (v < -mx - 1) begin f = 1'b1; return -mx - 1; end
    return v;
  endfunction

  task automatic model_beat(input int re, input int im, input int l);
    if (m_cnt == 0) begin
      m_len  = (l == 0) ? 1 : l;
      a_re_w = re; a_im_w = im; a_re_s = re; a_im_s = im;
      o_w = 1'b0; o_s = 1'b0;
      m_cnt = 1;
    end else begin
      a_re_w = sat(a_re_w + re, AW, o_w);
      a_im_w = sat(a_im_w + im, AW, o_w);
      a_re_s = sat(a_re_s + re, AWS, o_s);
      a_im_s = sat(a_im_s + im, AWS, o_s);
      m_cnt++;
    end
    if (m_cnt == m_len) begin
      sb.push_back('{a_re_w, a_im_w, a_re_s, a_im_s, o_w, o_s});
      m_cnt = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one beat, holds it until accepted, then returns 1ns after the accepting edge.
  task automatic beat(input int re, input int im, input int l);
    int g = 0;
    in_val  = 1'b1;
    in_data = {IW'(re), IW'(im)};
    len     = LW'(l);
    while (!in_ready && g < 200) begin step(); g++; end
    if (g >= 200) chk("accept_timeout", in_ready, 1);
    step();
    in_val  = 1'b0;
    in_data = (2*IW)'({$urandom, $urandom});
    len     = LW'($urandom);
    model_beat(re, im, l);
  endtask

  task automatic wait_idle();
    int g = 0;
    while (!(in_ready && sb.size() == 0) && g < 200) begin step(); g++; end
    if (g >= 200) chk("idle_timeout", in_ready && (sb.size() == 0), 1);
  endtask

  always @(negedge clk) begin
    if (out_val && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_depth", sb.size(), 1);
      end else begin
        exp_t e;
        logic signed [AW-1:0]  rw, iw;
        logic signed [AWS-1:0] rs, is_;
        e   = sb.pop_front();
        rw  = out_data[2*AW-1:AW];
        iw  = out_data[AW-1:0];
        rs  = out_data_s[2*AWS-1:AWS];
        is_ = out_data_s[AWS-1:0];
        chk("re_w",  rw,  e.re_w);
        chk("im_w",  iw,  e.im_w);
        chk("ovf_w", out_ovf, e.ovf_w);
        chk("val_s", out_val_s, 1);
        chk("re_s",  rs,  e.re_s);
        chk("im_s",  is_, e.im_s);
        chk("ovf_s", out_ovf_s, e.ovf_s);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached with %0d entries pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [AW-1:0] t_re, t_im;

    #13;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_in_ready_s", in_ready_s, 1);
    chk("rst_out_val", out_val, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ovf", out_ovf, 0);
    rstn = 1'b1;
    step();

    // single-beat product with one-cycle latency
    beat(2, 16, 1);
    chk("t1_out_val", out_val, 1);
    chk("t1_in_ready", in_ready, 0);
    step();
    chk("t1_back_idle", in_ready, 1);
    wait_idle();

    // three beats with stalls and a len change after the first beat
    beat(2, 16, 3);
    step(); step();
    beat(-5, 3, 50);
    chk("t2_no_early_val", out_val, 0);
    beat(10, -20, 7);
    chk("t2_out_val", out_val, 1);
    wait_idle();

    // backpressure holds the result
    out_ready = 1'b0;
    beat(2, 16, 3);
    beat(-5, 3, 3);
    beat(10, -20, 3);
    for (int i = 0; i < 5; i++) begin
      t_re = out_data[2*AW-1:AW];
      t_im = out_data[AW-1:0];
      chk("t3_hold_val", out_val, 1);
      chk("t3_hold_rdy", in_ready, 0);
      chk("t3_hold_re", t_re, 7);
      chk("t3_hold_im", t_im, -1);
      if (i < 4) step();
    end
    out_ready = 1'b1;
    step();
    chk("t3_released_val", out_val, 0);
    chk("t3_released_rdy", in_ready, 1);
    wait_idle();

    // saturation in the 18-bit instance, then a clean transaction
    beat(131071, -131072, 2);
    beat(1, -1, 2);
    wait_idle();
    beat(5, 5, 1);
    wait_idle();

    // saturation in the 24-bit instance
    for (int i = 0; i < 70; i++) beat(131071, -131072, 70);
    wait_idle();

    // software reset mid-transaction, with a competing beat presented
    beat(100, 100, 4);
    beat(100, 100, 4);
    sw_rst  = 1'b1;
    in_val  = 1'b1;
    in_data = {IW'(100), IW'(100)};
    step();
    sw_rst = 1'b0;
    in_val = 1'b0;
    m_cnt  = 0;
    chk("t5_in_ready", in_ready, 1);
    chk("t5_out_val", out_val, 0);
    chk("t5_out_data", out_data, 0);
    beat(1, 1, 2);
    beat(1, 1, 2);
    wait_idle();

    // randomised transactions with stalls and backpressure
    for (int t = 0; t < 20; t++) begin
      int l, n;
      l = int'($urandom_range(0, 6));
      n = (l == 0) ? 1 : l;
      out_ready = 1'($urandom_range(0, 1));
      for (int k = 0; k < n; k++) begin
        beat(int'($urandom_range(0, 262143)) - 131072,
             int'($urandom_range(0, 262143)) - 131072, l);
        repeat ($urandom_range(0, 2)) step();
      end
      repeat ($urandom_range(0, 3)) step();
      out_ready = 1'b1;
      wait_idle();
    end

    // len=0 treated as 1, then asynchronous reset while the result is held
    out_ready = 1'b0;
    beat(-3, 7, 0);
    chk("t6_out_val", out_val, 1);
    t_re = out_data[2*AW-1:AW];
    t_im = out_data[AW-1:0];
    chk("t6_re", t_re, -3);
    chk("t6_im", t_im, 7);
    #2;
    rstn = 1'b0;
    #1;
    chk("t6_async_val", out_val, 0);
    chk("t6_async_data", out_data, 0);
    chk("t6_async_ovf", out_ovf, 0);
    chk("t6_async_rdy", in_ready, 1);
    sb.delete();
    m_cnt = 0;
    #2;
    rstn = 1'b1;
    out_ready = 1'b1;
    step();
    beat(4, -4, 1);
    wait_idle();

    chk("sb_final", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
